// File: rtl/uart_controller_if.sv
// uart_controller_if: serial line pair plus transmit/receive byte streams
interface uart_controller_if;
  logic       receive_uart;
  logic       transmit_uart;
  logic [7:0] transmit_data;
  logic       transmit_valid;
  logic       transmit_ready;
  logic [7:0] receive_data;
  logic       receive_valid;
  logic       receive_ready;
  modport slave (
    input  receive_uart, transmit_data, transmit_valid, receive_ready,
    output transmit_uart, transmit_ready, receive_data, receive_valid
  );
  modport master (
    output receive_uart, transmit_data, transmit_valid, receive_ready,
    input  transmit_uart, transmit_ready, receive_data, receive_valid
  );
endinterface

// File: rtl/uart_controller.sv
// uart_controller: full-duplex 8N1 UART bridging serial lines and byte valid/ready streams
module uart_controller #(
  parameter int BAUD_RATE       = 115200,
  parameter int CLOCK_FREQUENCY = 100000000
) (
  input logic             clock,
  input logic             reset,
  uart_controller_if.slave bus
);
  localparam int CPB = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t rx_state_q, rx_state_d, tx_state_q, tx_state_d;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d, tx_line_q, tx_line_d;
  logic          rx, rx_good;
  assign rx     = sync_q[1];
  assign sync_d = {sync_q[0], bus.receive_uart};
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_good    = 1'b0;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        if (!rx) rx_state_d = START;
      end
      START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d   = '0;
        rx_state_d = rx ? IDLE : DATA;
      end
      DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == 3'd7) rx_state_d = STOP;
      end
      STOP: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d   = '0;
        rx_good    = rx;
        rx_state_d = IDLE;
      end
      default: rx_state_d = IDLE;
    endcase
    // a completed byte only lands if the holding register is empty or being drained this cycle
    rx_valid_d = rx_valid_q & ~bus.receive_ready;
    rx_data_d  = rx_data_q;
    if (rx_good && !rx_valid_d) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_shift_q;
    end
  end
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d  = '0;
        tx_bit_d  = '0;
        tx_line_d = 1'b1;
        if (bus.transmit_valid) begin
          tx_shift_d = bus.transmit_data;
          tx_line_d  = 1'b0;
          tx_state_d = START;
        end
      end
      START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_line_d  = tx_shift_q[0];
        tx_state_d = DATA;
      end
      DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_line_d  = 1'b1;
          tx_state_d = STOP;
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_line_d  = tx_shift_q[1];
        end
      end
      STOP: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d   = '0;
        tx_state_d = IDLE;
      end
      default: tx_state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end
  assign bus.transmit_uart  = tx_line_q;
  assign bus.transmit_ready = (tx_state_q == IDLE);
  assign bus.receive_data   = rx_data_q;
  assign bus.receive_valid  = rx_valid_q;
endmodule

// File: tb/tb_uart_controller.sv
// tb_uart_controller: directed and random checks of uart_controller at 10 clocks per bit
module tb_uart_controller;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx_drv = 1'b1;
  logic loop = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int n1, n2, t0, t1;
  bit exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] b;
  always #5 clock = ~clock;
  always @(posedge clock) cyc_n <= cyc_n + 1;
  uart_controller_if ifc();
  assign ifc.receive_uart = loop ? ifc.transmit_uart : rx_drv;
  uart_controller #(.BAUD_RATE(10), .CLOCK_FREQUENCY(100)) dut (
    .clock(clock),
    .reset(reset),
    .bus(ifc.slave)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      cyc(10);
    end
    rx_drv = 1'b1;
    if (stop && !exp_valid) begin
      exp_valid = 1'b1;
      exp_data  = d;
    end
  endtask
  task automatic rx_check(input string tag);
    chk({tag, "_valid"}, 32'(ifc.receive_valid), 32'(exp_valid));
    if (exp_valid) chk({tag, "_data"}, 32'(ifc.receive_data), 32'(exp_data));
  endtask
  task automatic consume();
    ifc.receive_ready = 1'b1;
    cyc(1);
    ifc.receive_ready = 1'b0;
    exp_valid = 1'b0;
    chk("consume_valid", 32'(ifc.receive_valid), 0);
  endtask
  task automatic tx_byte(input logic [7:0] d);
    logic [9:0] f;
    f = {1'b1, d, 1'b0};
    chk("tx_ready_pre", 32'(ifc.transmit_ready), 1);
    ifc.transmit_data  = d;
    ifc.transmit_valid = 1'b1;
    cyc(1);
    ifc.transmit_valid = 1'b0;
    ifc.transmit_data  = ~d;
    chk("tx_ready_busy", 32'(ifc.transmit_ready), 0);
    chk("tx_start_edge", 32'(ifc.transmit_uart), 0);
    cyc(5);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("tx_bit%0d", k), 32'(ifc.transmit_uart), 32'(f[k]));
      if (k < 9) cyc(10);
    end
    cyc(4);
    chk("tx_ready_99", 32'(ifc.transmit_ready), 0);
    cyc(1);
    chk("tx_ready_100", 32'(ifc.transmit_ready), 1);
  endtask
  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    ifc.transmit_data  = 8'h00;
    ifc.transmit_valid = 1'b0;
    ifc.receive_ready  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(50);
      chk("rst_tx_line", 32'(ifc.transmit_uart), 1);
      chk("rst_tx_ready", 32'(ifc.transmit_ready), 1);
      chk("rst_rx_valid", 32'(ifc.receive_valid), 0);
      chk("rst_rx_data", 32'(ifc.receive_data), 0);
    end
    reset = 1'b1;
    cyc(5);
    rx_frame(8'hAA, 1'b1);
    rx_check("rx_aa");
    cyc(30);
    rx_check("rx_aa_hold");
    consume();
    rx_frame(8'h3C, 1'b1);
    rx_frame(8'h81, 1'b1);
    rx_check("overrun_keep");
    consume();
    rx_frame(8'h81, 1'b1);
    rx_check("rx_81");
    consume();
    rx_drv = 1'b0;
    cyc(3);
    rx_drv = 1'b1;
    cyc(30);
    chk("glitch_none", 32'(ifc.receive_valid), 0);
    rx_frame(8'h5A, 1'b0);
    cyc(20);
    chk("frame_err_none", 32'(ifc.receive_valid), 0);
    rx_frame(8'h55, 1'b1);
    rx_check("rx_55");
    consume();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      rx_frame(b, 1'b1);
      rx_check("rx_rand");
      cyc($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) consume();
    end
    if (exp_valid) consume();
    tx_byte(8'hA5);
    for (int i = 0; i < 3; i++) tx_byte(8'($urandom));
    cyc(5);
    loop = 1'b1;
    fork
      begin
        ifc.transmit_data  = 8'h00;
        ifc.transmit_valid = 1'b1;
        n1 = 0;
        while (!ifc.transmit_ready && n1 < 500) begin cyc(1); n1++; end
        cyc(1);
        t0 = cyc_n;
        ifc.transmit_data = 8'hFF;
        n1 = 0;
        while (!ifc.transmit_ready && n1 < 500) begin cyc(1); n1++; end
        cyc(1);
        t1 = cyc_n;
        ifc.transmit_valid = 1'b0;
        chk("lb_b2b_spacing", 32'(t1 - t0), 101);
      end
      begin
        for (int j = 0; j < 2; j++) begin
          n2 = 0;
          while (!ifc.receive_valid && n2 < 500) begin cyc(1); n2++; end
          chk("lb_timeout", 32'(n2 < 500), 1);
          chk($sformatf("lb_byte%0d", j), 32'(ifc.receive_data), (j == 0) ? 32'h00 : 32'hFF);
          ifc.receive_ready = 1'b1;
          cyc(1);
          ifc.receive_ready = 1'b0;
        end
      end
    join
    cyc(20);
    loop = 1'b0;
    exp_valid = 1'b0;
    cyc(5);
    ifc.transmit_data  = 8'h0F;
    ifc.transmit_valid = 1'b1;
    cyc(1);
    ifc.transmit_valid = 1'b0;
    cyc(30);
    chk("mid_tx_busy", 32'(ifc.transmit_ready), 0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_line", 32'(ifc.transmit_uart), 1);
    chk("async_rst_ready", 32'(ifc.transmit_ready), 1);
    chk("async_rst_valid", 32'(ifc.receive_valid), 0);
    cyc(3);
    reset = 1'b1;
    cyc(3);
    rx_frame(8'hC3, 1'b1);
    rx_check("post_rst_rx");
    consume();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
